pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Parametrised next-generation program counter for the fetch stage. It drives the instruction-memory address and a valid flag.
- Adds the following over the basic PC:
  - configurable width, instruction size and reset vector;
  - an exception redirect input;
  - capture of a redirect that arrives while the pipeline is stalled (never dropped);
  - a programmable flush-bubble window after each redirect.
- Sits between the hazard/branch unit and instruction memory.

Parameters:
- WIDTH, 32, address/PC width in bits.
- RESET_ADDR, 32'd0, PC value on reset.
- INSTR_BYTES, 2, sequential increment (2 = Thumb, 4 = 32-bit).
- EXC_VECTOR, 32'h0000_0008, PC target on exception.
- FLUSH_CYCLES, 1, number of invalid cycles after a redirect is applied. Range 0..7.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- stall_pipeline_i  in  stall_pipeline_sig  STALL_PIPELINE holds the PC.
- take_branch_i  in  take_branch_ctrl_sig  TAKE_BRANCH requests a redirect to branch_pc_value_i.
- branch_pc_value_i  in  WIDTH  branch target; bit 0 is the Thumb bit.
- exception_i  in  1  redirect to EXC_VECTOR.
- redirect_pending_o  out  1  a redirect is captured and waiting for the stall to drop.
- is_valid_o  out  1  program_counter_o addresses a real instruction.
- program_counter_o  out  WIDTH  current fetch address.

Behaviour:
- Reset (asynchronous, any time, including mid-flush or with a redirect pending):
  - program_counter_o = RESET_ADDR, is_valid_o = 1, redirect_pending_o = 0;
  - pending target cleared, state = RUN, flush counter = 0.
- Redirect target rules:
  - branch target = {branch_pc_value_i[WIDTH-1:1], 1'b0} (Thumb bit always cleared);
  - exception target = EXC_VECTOR.
- Priority in each cycle: exception_i > take_branch_i > pending redirect > stall > increment.
- States: RUN, PENDING, FLUSH. All outputs are registered; every update takes effect at the clock edge.
- RUN:
  - Not stalled, new redirect: PC <= target. If FLUSH_CYCLES > 0, go to FLUSH, load counter = FLUSH_CYCLES, is_valid_o <= 0. Otherwise stay in RUN with is_valid_o = 1.
  - Stalled, new redirect: latch target, go to PENDING, redirect_pending_o <= 1, PC held.
  - Stalled, no redirect: PC held, is_valid_o unchanged.
  - Otherwise: PC <= PC + INSTR_BYTES, truncated to WIDTH bits (wraps to 0, no flag).
- PENDING:
  - PC held, is_valid_o = 0.
  - A further redirect while stalled overwrites the latched target only if its priority is equal or higher. A later branch replaces an earlier branch. A branch never replaces a latched exception.
  - First non-stalled cycle: apply the latched target (or a same-cycle exception/branch, by priority), clear redirect_pending_o, then enter FLUSH or RUN as in RUN.
- FLUSH:
  - PC holds the target, is_valid_o = 0.
  - Counter decrements every cycle, stalled or not.
  - On the cycle the counter reaches 0: is_valid_o <= 1, state = RUN. The next sequential increment occurs the following unstalled cycle.
  - Redirect during FLUSH (stalled or not): apply immediately (PC <= new target) and reload the counter. Stall has no effect on applying redirects in this state.
- Latency: a redirect with no stall changes program_counter_o at the next edge. The target is presented valid FLUSH_CYCLES cycles later.
- redirect_pending_o is asserted only in PENDING.

Test Plan:
- Reset then free-run 4 cycles (INSTR_BYTES = 2) -> PC sequence 0, 2, 4, 6, 8; is_valid_o = 1 throughout.
- Branch to 0x0000_0101, no stall, FLUSH_CYCLES = 1:
  - PC = 0x100 with is_valid_o = 0 for 1 cycle;
  - then 0x100 valid, then 0x102.
- Stall 3 cycles with a branch to 0x40 in stall cycle 1 and 0x80 in cycle 2:
  - PC held, redirect_pending_o = 1;
  - after the stall drops, PC = 0x80; 0x40 is never issued.
- During a stall, exception_i followed by a branch to 0x200 -> after the stall, PC = EXC_VECTOR (0x8) and the branch is ignored.
- PC = 0xFFFF_FFFE, increment -> PC = 0x0000_0000, is_valid_o = 1.
- Assert reset_i asynchronously in PENDING and mid-FLUSH -> outputs immediately return to RESET_ADDR, valid = 1, pending = 0. Also run with FLUSH_CYCLES = 0: a branch is valid on the next cycle.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program counter with branch/exception redirects,
// redirect capture across stalls and a programmable post-redirect flush window.
module pc_sequencer #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_ADDR   = '0,
    parameter int               INSTR_BYTES  = 2,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_0008),
    parameter int               FLUSH_CYCLES = 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             stall_pipeline_i,
    input  logic             take_branch_i,
    input  logic [WIDTH-1:0] branch_pc_value_i,
    input  logic             exception_i,
    output logic             redirect_pending_o,
    output logic             is_valid_o,
    output logic [WIDTH-1:0] program_counter_o
);
    typedef enum logic [1:0] {RUN, PENDING, FLUSH} state_t;
    localparam logic [2:0] FLUSH_LD = 3'(FLUSH_CYCLES);

    state_t           r_state, w_state_n;
    logic [WIDTH-1:0] r_pc, w_pc_n, r_ptgt, w_ptgt_n, w_tgt, w_apply_tgt;
    logic             r_valid, w_valid_n, r_pexc, w_pexc_n, w_redir, w_apply;
    logic [2:0]       r_cnt, w_cnt_n;

    always_comb begin
        // Masking bit 0 clears the Thumb bit of the branch target
        w_tgt       = exception_i ? EXC_VECTOR : (branch_pc_value_i & ~WIDTH'(1));
        w_redir     = exception_i | take_branch_i;
        w_state_n   = r_state;
        w_pc_n      = r_pc;
        w_valid_n   = r_valid;
        w_ptgt_n    = r_ptgt;
        w_pexc_n    = r_pexc;
        w_cnt_n     = r_cnt;
        w_apply     = 1'b0;
        w_apply_tgt = w_tgt;
        case (r_state)
            RUN: begin
                if (w_redir && stall_pipeline_i) begin
                    w_state_n = PENDING;
                    w_ptgt_n  = w_tgt;
                    w_pexc_n  = exception_i;
                    w_valid_n = 1'b0;
                end else if (w_redir) begin
                    w_apply = 1'b1;
                end else if (!stall_pipeline_i) begin
                    w_pc_n = r_pc + WIDTH'(INSTR_BYTES);
                end
            end
            PENDING: begin
                if (!stall_pipeline_i) begin
                    w_apply     = 1'b1;
                    w_apply_tgt = w_redir ? w_tgt : r_ptgt;
                end else if (exception_i || (take_branch_i && !r_pexc)) begin
                    // A latched exception is only displaced by another exception
                    w_ptgt_n = w_tgt;
                    w_pexc_n = exception_i;
                end
            end
            FLUSH: begin
                if (w_redir) begin
                    w_apply = 1'b1;
                end else begin
                    w_cnt_n = r_cnt - 3'd1;
                    if (r_cnt == 3'd1) begin
                        w_valid_n = 1'b1;
                        w_state_n = RUN;
                    end
                end
            end
            default: w_state_n = RUN;
        endcase
        if (w_apply) begin
            w_pc_n    = w_apply_tgt;
            w_cnt_n   = FLUSH_LD;
            w_valid_n = (FLUSH_CYCLES == 0);
            w_state_n = (FLUSH_CYCLES == 0) ? RUN : FLUSH;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= RUN;
            r_pc    <= RESET_ADDR;
            r_valid <= 1'b1;
            r_ptgt  <= '0;
            r_pexc  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_n;
            r_pc    <= w_pc_n;
            r_valid <= w_valid_n;
            r_ptgt  <= w_ptgt_n;
            r_pexc  <= w_pexc_n;
            r_cnt   <= w_cnt_n;
        end
    end

    assign redirect_pending_o = (r_state == PENDING);
    assign is_valid_o         = r_valid;
    assign program_counter_o  = r_pc;
endmodule
